// File: rtl/gpu_inst_encoder_if.sv
// gpu_inst_encoder_if: host byte stream in, instruction FIFO write side and error status out.
interface gpu_inst_encoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [81:0] fifo_wdata;
    logic        pkt_err;
    logic [7:0]  err_count;
    logic        busy;
    modport master (output rx_data, rx_valid, fifo_full,
                    input rx_ready, fifo_wr_en, fifo_wdata, pkt_err, err_count, busy);
    modport slave (input rx_data, rx_valid, fifo_full,
                   output rx_ready, fifo_wr_en, fifo_wdata, pkt_err, err_count, busy);
endinterface

// File: rtl/gpu_inst_encoder.sv
// gpu_inst_encoder: assembles sync+11 payload+XOR-checksum byte packets into 82-bit
// instruction words and writes them to the instruction FIFO; malformed packets are counted.
module gpu_inst_encoder #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1023
) (
    input logic clk,
    input logic rst,
    gpu_inst_encoder_if.slave bus
);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, PUSH} state_t;
    state_t        state_q;
    logic [3:0]    byte_cnt_q;
    logic [7:0]    xor_q;
    logic [87:0]   sr_q;
    logic [IW-1:0] idle_q, idle_d;
    logic [81:0]   wdata_q;
    logic          err_q;
    logic [7:0]    cnt_q;
    logic          acc, in_pkt, tmo, ok, drop;
    assign bus.rx_ready   = state_q != PUSH;
    assign bus.fifo_wr_en = state_q == PUSH && !bus.fifo_full;
    assign bus.fifo_wdata = wdata_q;
    assign bus.pkt_err    = err_q;
    assign bus.err_count  = cnt_q;
    assign bus.busy       = state_q != IDLE;
    always_comb begin
        acc    = bus.rx_valid && bus.rx_ready;
        in_pkt = state_q == PAYLOAD || state_q == CHECK;
        idle_d = acc ? '0 : idle_q + 1'b1;
        tmo    = in_pkt && !acc && idle_d == IW'(TIMEOUT_CYC);
        ok     = bus.rx_data == xor_q && sr_q[87:82] == 6'd0;
        drop   = tmo || (state_q == CHECK && acc && !ok);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            xor_q      <= '0;
            sr_q       <= '0;
            idle_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            err_q  <= drop;
            idle_q <= in_pkt ? idle_d : '0;
            if (drop && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            case (state_q)
                IDLE: if (acc && bus.rx_data == SYNC_BYTE) begin
                    state_q    <= PAYLOAD;
                    byte_cnt_q <= '0;
                    xor_q      <= '0;
                end
                PAYLOAD: if (tmo) state_q <= IDLE;
                else if (acc) begin
                    sr_q       <= {sr_q[79:0], bus.rx_data};
                    xor_q      <= xor_q ^ bus.rx_data;
                    byte_cnt_q <= byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd10) state_q <= CHECK;
                end
                CHECK: if (tmo) state_q <= IDLE;
                else if (acc) begin
                    state_q <= ok ? PUSH : IDLE;
                    if (ok) wdata_q <= sr_q[81:0];
                end
                default: if (bus.fifo_wr_en) state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_inst_encoder.sv
// tb_gpu_inst_encoder: randomized packet stimulus checked every cycle against a
// queue-based packet model, plus literal expectations for the directed scenarios.
module tb_gpu_inst_encoder;
    localparam int TO = 1023;
    logic clk = 0, rst = 1;
    gpu_inst_encoder_if bus();
    gpu_inst_encoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0, errors = 0, wr_cnt = 0;
    bit gaps = 0, rand_full = 0;

    task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: packet bytes kept in a queue, decision made when the 12th byte arrives
    int m_mode, m_gap, m_cnt;
    logic [7:0] m_q[$];
    logic [7:0] m_x;
    logic [81:0] m_wdata;
    logic m_err, m_acc, m_drop;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_gap = 0; m_cnt = 0; m_q.delete(); m_wdata = '0; m_err = 0;
        end else begin
            m_acc = bus.rx_valid && m_mode != 2;
            m_drop = 0;
            if (m_mode == 0) begin
                if (m_acc && bus.rx_data == 8'hA5) begin m_mode = 1; m_q.delete(); m_gap = 0; end
            end else if (m_mode == 1) begin
                if (m_acc) begin
                    m_q.push_back(bus.rx_data);
                    m_gap = 0;
                    if (m_q.size() == 12) begin
                        m_x = 0;
                        for (int i = 0; i < 11; i++) m_x ^= m_q[i];
                        if (m_x == m_q[11] && m_q[0][7:2] == 6'd0) begin
                            m_wdata = {m_q[0][1:0], 80'b0};
                            for (int i = 1; i <= 10; i++) m_wdata[(10-i)*8 +: 8] = m_q[i];
                            m_mode = 2;
                        end else begin
                            m_drop = 1; m_mode = 0;
                        end
                    end
                end else begin
                    m_gap++;
                    if (m_gap == TO) begin m_drop = 1; m_mode = 0; end
                end
            end else if (!bus.fifo_full) m_mode = 0;
            m_err = m_drop;
            if (m_drop && m_cnt < 255) m_cnt++;
        end
    end

    always @(negedge clk) begin
        chk("rx_ready", bus.rx_ready, m_mode != 2);
        chk("busy", bus.busy, m_mode != 0);
        chk("fifo_wr_en", bus.fifo_wr_en, m_mode == 2 && !bus.fifo_full);
        chk("fifo_wdata", bus.fifo_wdata, m_wdata);
        chk("pkt_err", bus.pkt_err, m_err);
        chk("err_count", bus.err_count, 82'(m_cnt));
    end

    always @(posedge clk) if (bus.fifo_wr_en) wr_cnt++;

    initial forever begin
        @(posedge clk); #1;
        if (rand_full) bus.fifo_full = ($urandom_range(0, 2) == 0);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        bit ok;
        bus.rx_data = b; bus.rx_valid = 1; g = 0;
        do begin ok = bus.rx_ready; @(posedge clk); #1; g++; end while (!ok && g < 500);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_byte: rx_ready got 0 for 500 cycles expected 1");
        end
        bus.rx_valid = 0;
        if (gaps) tick($urandom_range(0, 2));
    endtask

    task automatic send_pkt(input logic [87:0] pl, input logic [7:0] flip);
        logic [7:0] x;
        x = 0;
        send_byte(8'hA5);
        for (int i = 0; i < 11; i++) begin
            send_byte(pl[87-8*i -: 8]);
            x ^= pl[87-8*i -: 8];
        end
        send_byte(x ^ flip);
    endtask

    function automatic logic [87:0] rnd_pl();
        logic [87:0] p;
        p[31:0] = $urandom; p[63:32] = $urandom; p[87:64] = 24'($urandom);
        p[87:82] = ($urandom_range(0, 7) == 0) ? 6'd1 : 6'd0;
        return p;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.rx_data = 0; bus.rx_valid = 0; bus.fifo_full = 0;
        tick(2);
        rst = 0;
        chk("reset rx_ready", bus.rx_ready, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset wdata", bus.fifo_wdata, 0);
        chk("reset err_count", bus.err_count, 0);
        // Good packet
        send_pkt(88'h02_00000000000000000001, 8'h00);
        tick(2);
        chk("t1 wdata", bus.fifo_wdata, 82'h2_0000_0000_0000_0000_0001);
        chk("t1 writes", wr_cnt, 1);
        // Bad checksum (04 instead of 03)
        send_pkt(88'h02_00000000000000000001, 8'h07);
        tick(2);
        chk("t2 err_count", bus.err_count, 1);
        chk("t2 writes", wr_cnt, 1);
        // FIFO full stall in PUSH
        bus.fifo_full = 1;
        send_pkt(88'h01_0123456789ABCDEF0123, 8'h00);
        tick(20);
        chk("t3 rx_ready", bus.rx_ready, 0);
        chk("t3 wdata", bus.fifo_wdata, 82'h1_0123_4567_89AB_CDEF_0123);
        chk("t3 writes", wr_cnt, 1);
        bus.fifo_full = 0;
        tick(2);
        chk("t3 writes after", wr_cnt, 2);
        chk("t3 busy", bus.busy, 0);
        // Junk bytes ignored, reserved bit drops packet
        send_byte(8'h00); send_byte(8'hFF);
        chk("t4 junk err_count", bus.err_count, 1);
        send_pkt(88'h04_00000000000000000001, 8'h00);
        tick(2);
        chk("t4 err_count", bus.err_count, 2);
        // Timeout after 5 payload bytes
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(8'h11);
        tick(TO + 3);
        chk("t5 err_count", bus.err_count, 3);
        chk("t5 busy", bus.busy, 0);
        send_pkt(88'h03_FFFFFFFFFFFFFFFFFFFF, 8'h00);
        tick(2);
        chk("t5 wdata", bus.fifo_wdata, 82'h3_FFFF_FFFF_FFFF_FFFF_FFFF);
        chk("t5 writes", wr_cnt, 3);
        // Reset mid-PAYLOAD
        send_byte(8'hA5);
        for (int i = 0; i < 3; i++) send_byte(8'h22);
        #2 rst = 1;
        #1;
        chk("t6a busy", bus.busy, 0);
        chk("t6a err_count", bus.err_count, 0);
        chk("t6a wdata", bus.fifo_wdata, 0);
        chk("t6a rx_ready", bus.rx_ready, 1);
        @(posedge clk); #1 rst = 0;
        // Reset mid-PUSH
        bus.fifo_full = 1;
        send_pkt(88'h02_AAAAAAAAAAAAAAAAAAAA, 8'h00);
        tick(2);
        #2 rst = 1;
        #1;
        chk("t6b wr_en", bus.fifo_wr_en, 0);
        chk("t6b wdata", bus.fifo_wdata, 0);
        chk("t6b pkt_err", bus.pkt_err, 0);
        @(posedge clk); #1 rst = 0;
        bus.fifo_full = 0;
        tick(3);
        chk("t6b writes", wr_cnt, 3);
        // Randomized traffic
        w = wr_cnt;
        gaps = 1; rand_full = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) send_byte(8'h3C);
            send_pkt(rnd_pl(), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        end
        rand_full = 0;
        tick(1);
        bus.fifo_full = 0;
        tick(3);
        chk("random some writes", wr_cnt > w, 1);
        // Saturation
        gaps = 0;
        for (int n = 0; n < 300; n++) send_pkt(rnd_pl() & 88'h03_FFFFFFFFFFFFFFFFFFFF, 8'h5A);
        tick(3);
        chk("sat err_count", bus.err_count, 8'hFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
